// File: rtl/alu_pkg.sv
// Shared ALU opcodes, slice selects and sequencer state type.
// Imported by the serial sequencer and the one-bit slice.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;

  localparam logic [2:0] SEL_AND  = 3'b000;
  localparam logic [2:0] SEL_OR   = 3'b001;
  localparam logic [2:0] SEL_ADD  = 3'b010;
  localparam logic [2:0] SEL_SUB  = 3'b011;
  localparam logic [2:0] SEL_NONE = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [2:0] op2sel(
    input logic [2:0] op
  );
    logic [2:0] s;
    s = SEL_NONE;
    unique case (1'b1)
      op == OP_AND: s = SEL_AND;
      op == OP_OR:  s = SEL_OR;
      op == OP_ADD: s = SEL_ADD;
      op == OP_SUB: s = SEL_SUB;
      op == OP_SLT: s = SEL_SUB;
      default:      s = SEL_NONE;
    endcase
    return s;
  endfunction

  // SUB and SLT both compute a + ~b + 1
  function automatic logic op_inv(
    input logic [2:0] op
  );
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Start/done bus of the serial ALU: request, operands, result, flags.
// master = requester (drives start/op/a/b), slave = serial_alu_ctrl.
interface serial_alu_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result,
    input  carry_out, overflow, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result,
    output carry_out, overflow, zero
  );
endinterface

// File: rtl/ALU_bitSlice.sv
// One-bit ALU slice: AND / OR / full-add, zero for other selects.
// Ports: A, B, Cin, sel[2:0] in; out, Cout out.
module ALU_bitSlice
  import alu_pkg::*;
(
  input  logic       A,
  input  logic       B,
  input  logic       Cin,
  input  logic [2:0] sel,
  output logic       out,
  output logic       Cout
);

  always_comb begin
    out  = 1'b0;
    Cout = 1'b0;
    unique case (1'b1)
      sel == SEL_AND: out = A & B;
      sel == SEL_OR:  out = A | B;
      (sel == SEL_ADD) || (sel == SEL_SUB): begin
        out  = A ^ B ^ Cin;
        Cout = (A & B) | (Cin & (A ^ B));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: one slice, WIDTH cycles LSB first.
// Ports: clk, rst_n, bus (slave: start/op/a/b -> busy/done/result/flags).
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  serial_alu_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic [2:0]         r_op;
  logic               r_carry;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;
  logic               r_ovf;
  logic               r_zero;

  logic               w_last;
  logic               w_inv;
  logic               w_arith;
  logic [2:0]         w_sel;
  logic               w_sb;
  logic               w_out;
  logic               w_cout;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_res_nxt;
  logic [WIDTH-1:0]   w_fin_res;
  logic               w_fin_c;
  logic               w_fin_v;

  assign w_last  = r_cnt == CNT_W'(WIDTH - 1);
  assign w_inv   = op_inv(r_op);
  assign w_sel   = op2sel(r_op);
  assign w_arith = (r_op == OP_ADD) ||
                   (r_op == OP_SUB) ||
                   (r_op == OP_SLT);
  assign w_sb    = r_b[0] ^ w_inv;

  ALU_bitSlice u_slice (
    .A    (r_a[0]),
    .B    (w_sb),
    .Cin  (r_carry),
    .sel  (w_sel),
    .out  (w_out),
    .Cout (w_cout)
  );

  assign w_res_nxt = {w_out, r_res[WIDTH-1:1]};
  // carry into MSB xor carry out of MSB
  assign w_ovf     = r_carry ^ w_cout;

  always_comb begin
    w_fin_res = w_res_nxt;
    w_fin_c   = 1'b0;
    w_fin_v   = 1'b0;
    unique case (1'b1)
      (r_op == OP_ADD) || (r_op == OP_SUB): begin
        w_fin_c = w_cout;
        w_fin_v = w_ovf;
      end
      r_op == OP_SLT: begin
        // sign of true difference = sum_msb ^ overflow
        w_fin_res = {{(WIDTH-1){1'b0}}, w_out ^ w_ovf};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = SHIFT;
      SHIFT:   if (w_last)    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_op     <= OP_AND;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_op    <= bus.op;
            r_cnt   <= '0;
            r_res   <= '0;
            r_carry <= op_inv(bus.op);
          end
        end
        SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= w_res_nxt;
          r_carry <= w_arith ? w_cout : 1'b0;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_result <= w_fin_res;
            r_cout   <= w_fin_c;
            r_ovf    <= w_fin_v;
            r_zero   <= w_fin_res == '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_state != IDLE;
  assign bus.done      = r_state == DONE;
  assign bus.result    = r_result;
  assign bus.carry_out = r_cout;
  assign bus.overflow  = r_ovf;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Bench for serial_alu_ctrl (WIDTH=8): directed ops, scoreboard monitor.
// Stimulus pushes expected results; monitor pops on done.
module tb_serial_alu_ctrl;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t  sb[$];
  string nq[$];

  serial_alu_ctrl_if #(.WIDTH(W)) ifc ();

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] req
  );
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(
    input logic [W-1:0] r,
    input logic c,
    input logic v,
    input logic z
  );
    exp_t e;
    e.res = r;
    e.c   = c;
    e.v   = v;
    e.z   = z;
    return e;
  endfunction

  always @(negedge clk) begin
    if (ifc.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t  e;
        string n;
        e = sb.pop_front();
        n = nq.pop_front();
        chk(n, {ifc.result, ifc.carry_out,
                ifc.overflow, ifc.zero}, e);
      end
    end
  end

  // Called at a negedge; returns at the negedge of cycle W+2.
  task automatic run(
    input string      nm,
    input logic [2:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input exp_t       e,
    input logic [15:0] poke
  );
    int t;
    t = 0;
    while (ifc.busy !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk({nm, "_idle_timeout"}, 1, 0);
    ifc.op    = op;
    ifc.a     = a;
    ifc.b     = b;
    ifc.start = 1'b1;
    sb.push_back(e);
    nq.push_back(nm);
    @(posedge clk);
    #1;
    for (int k = 1; k <= W + 1; k++) begin
      ifc.start = poke[k];
      if (poke[k]) begin
        ifc.op = OP_SUB;
        ifc.a  = 8'hAA;
        ifc.b  = 8'h55;
      end
      @(negedge clk);
      chk({nm, "_busy"}, ifc.busy, 1);
      chk({nm, "_done"}, ifc.done, (k == W + 1));
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
    end
    @(negedge clk);
    chk({nm, "_idle_busy"}, ifc.busy, 0);
    chk({nm, "_idle_done"}, ifc.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    ifc.start = 1'b0;
    ifc.op    = OP_AND;
    ifc.a     = '0;
    ifc.b     = '0;
    #1;
    chk("rst_outs", {ifc.busy, ifc.done, ifc.result,
        ifc.carry_out, ifc.overflow, ifc.zero}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run("add_ff_01", OP_ADD, 8'hFF, 8'h01,
        mk(8'h00, 1, 0, 1), 16'h0);
    run("add_7f_01", OP_ADD, 8'h7F, 8'h01,
        mk(8'h80, 0, 1, 0), 16'h0);
    run("sub_05_07", OP_SUB, 8'h05, 8'h07,
        mk(8'hFE, 0, 0, 0), 16'h0);
    run("slt_80_01", OP_SLT, 8'h80, 8'h01,
        mk(8'h01, 0, 0, 0), 16'h0);
    run("slt_01_80", OP_SLT, 8'h01, 8'h80,
        mk(8'h00, 0, 0, 1), 16'h0);
    run("slt_33_33", OP_SLT, 8'h33, 8'h33,
        mk(8'h00, 0, 0, 1), 16'h0);
    run("and_f0_3c", OP_AND, 8'hF0, 8'h3C,
        mk(8'h30, 0, 0, 0), 16'h0);
    run("or_f0_3c", OP_OR, 8'hF0, 8'h3C,
        mk(8'hFC, 0, 0, 0), 16'h0);
    run("add_ignore", OP_ADD, 8'h10, 8'h20,
        mk(8'h30, 0, 0, 0), 16'h0208);
    run("add_next", OP_ADD, 8'h01, 8'h01,
        mk(8'h02, 0, 0, 0), 16'h0);

    ifc.op    = OP_SUB;
    ifc.a     = 8'h09;
    ifc.b     = 8'h04;
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {ifc.busy, ifc.done, ifc.result,
        ifc.carry_out, ifc.overflow, ifc.zero}, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 3) rst_n = 1'b1;
      chk("abort_no_done", ifc.done, 0);
    end

    run("add_02_03", OP_ADD, 8'h02, 8'h03,
        mk(8'h05, 0, 0, 0), 16'h0);
    run("illegal_101", 3'b101, 8'hFF, 8'hFF,
        mk(8'h00, 0, 0, 1), 16'h0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
